memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 40 ++++
 rtl/memory_arbiter.sv | 115 +++++++++++
 tb/tb_memory_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// ============================================================================
// Module  : memory_arbiter_if
// Brief   : Requester and RAM-side signal bundle for memory_arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface memory_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [1:0]  ramstate;
   logic [31:0] ramload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        iwait;
   logic        dwait;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ram_err;

   // Arbiter side
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, ram_err
   );

   // Requester / RAM side
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, ram_err
   );
endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module  : memory_arbiter
// Brief   : Two-requester RAM arbiter, data priority with instruction anti-starvation.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module memory_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   memory_arbiter_if.slave  bus
);

   localparam int           c_CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0]   c_IDLE       = 2'd0;
   localparam logic [1:0]   c_DGRANT     = 2'd1;
   localparam logic [1:0]   c_IGRANT     = 2'd2;
   localparam logic [1:0]   c_RAM_ACCESS = 2'd2;
   localparam logic [1:0]   c_RAM_ERROR  = 2'd3;
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_starve_cnt;
   logic [c_CNT_W-1:0] w_starve_nxt;
   logic [31:0]        r_addr;
   logic [31:0]        r_store;
   logic               r_wen;
   logic               w_grant;
   logic               w_access;
   logic               w_error;
   logic               w_dwin;
   logic               w_iwin;
   logic               w_idone;
   logic               w_ddone;

   assign w_grant  = (r_state == c_DGRANT) || (r_state == c_IGRANT);
   assign w_access = w_grant && (bus.ramstate == c_RAM_ACCESS);
   assign w_error  = w_grant && (bus.ramstate == c_RAM_ERROR);
   assign w_idone  = (r_state == c_IGRANT) && w_access;
   assign w_ddone  = (r_state == c_DGRANT) && w_access;

   // Data wins unless instruction has waited out STARVE_LIMIT data grants
   assign w_dwin = (r_state == c_IDLE) && (bus.dREN || bus.dWEN)
                   && !(bus.iREN && (r_starve_cnt == c_LIMIT));
   assign w_iwin = (r_state == c_IDLE) && !w_dwin && bus.iREN;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_dwin)
               w_state_nxt = c_DGRANT;
            else if (w_iwin)
               w_state_nxt = c_IGRANT;
         end
         c_DGRANT, c_IGRANT: begin
            if (w_access || w_error)
               w_state_nxt = c_IDLE;
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_ddone) begin
         if (!bus.iREN)
            w_starve_nxt = '0;
         else if (r_starve_cnt != c_LIMIT)
            w_starve_nxt = r_starve_cnt + c_CNT_W'(1);
      end else if (w_idone) begin
         w_starve_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_IDLE;
         r_starve_cnt <= '0;
         r_addr       <= '0;
         r_store      <= '0;
         r_wen        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         if (w_dwin) begin
            r_addr  <= bus.daddr;
            r_store <= bus.dstore;
            r_wen   <= bus.dWEN;
         end else if (w_iwin) begin
            r_addr  <= bus.iaddr;
            r_store <= '0;
            r_wen   <= 1'b0;
         end
      end
   end

   // RAM side is driven purely from latched state so requesters may change freely
   assign bus.ramREN   = (r_state == c_IGRANT) || ((r_state == c_DGRANT) && !r_wen);
   assign bus.ramWEN   = (r_state == c_DGRANT) && r_wen;
   assign bus.ramaddr  = r_addr;
   assign bus.ramstore = r_store;

   assign bus.iwait   = !w_idone;
   assign bus.dwait   = !w_ddone;
   assign bus.iload   = w_idone ? bus.ramload : 32'h0;
   assign bus.dload   = w_ddone ? bus.ramload : 32'h0;
   assign bus.ram_err = w_error;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module  : tb_memory_arbiter
// Brief   : Directed plus randomized self-checking bench for memory_arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memory_arbiter_if bus ();

   memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level model: who owns the RAM and what was captured at grant
   int          m_owner;   // 0 none, 1 data, 2 instruction
   logic [31:0] m_addr;
   logic [31:0] m_store;
   bit          m_write;
   int          m_streak;
   int          trace[$];
   bit          rec_en;
   bit          last_idone;
   bit          last_ddone;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_addr   = 32'h0;
      m_store  = 32'h0;
      m_write  = 1'b0;
      m_streak = 0;
   endtask

   // Called just after a falling edge with inputs already applied
   task automatic cycle();
      bit acc;
      bit err;
      #1;
      if (rst) model_reset();
      acc = (m_owner != 0) && (bus.ramstate == 2'd2);
      err = (m_owner != 0) && (bus.ramstate == 2'd3);
      chk("ramREN",   bus.ramREN,   (m_owner == 2) || (m_owner == 1 && !m_write));
      chk("ramWEN",   bus.ramWEN,   (m_owner == 1) && m_write);
      chk("ramaddr",  bus.ramaddr,  m_addr);
      chk("ramstore", bus.ramstore, m_store);
      chk("iwait",    bus.iwait,    !(m_owner == 2 && acc));
      chk("dwait",    bus.dwait,    !(m_owner == 1 && acc));
      chk("iload",    bus.iload,    (m_owner == 2 && acc) ? bus.ramload : 32'h0);
      chk("dload",    bus.dload,    (m_owner == 1 && acc) ? bus.ramload : 32'h0);
      chk("ram_err",  bus.ram_err,  err);
      if (rec_en && (bus.ramREN || bus.ramWEN))
         trace.push_back(bus.ramWEN ? 1 : 2);
      last_idone = (m_owner == 2) && acc;
      last_ddone = (m_owner == 1) && acc;
      if (!rst) begin
         if (m_owner != 0) begin
            if (acc) begin
               if (m_owner == 1)
                  m_streak = bus.iREN ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
               else
                  m_streak = 0;
               m_owner = 0;
            end else if (err) begin
               m_owner = 0;
            end
         end else if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak == LIMIT)) begin
            m_owner = 1;
            m_addr  = bus.daddr;
            m_store = bus.dstore;
            m_write = bus.dWEN;
         end else if (bus.iREN) begin
            m_owner = 2;
            m_addr  = bus.iaddr;
            m_store = 32'h0;
            m_write = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_random();
      logic [1:0] kind;
      int         r;
      if (!bus.iREN || last_idone) begin
         if ($urandom_range(0, 9) < 4) begin
            bus.iREN  = 1'b1;
            bus.iaddr = $urandom;
         end else begin
            bus.iREN = 1'b0;
         end
      end else if ($urandom_range(0, 49) == 0) begin
         bus.iREN = 1'b0;
      end
      if (!(bus.dREN || bus.dWEN) || last_ddone) begin
         if ($urandom_range(0, 9) < 5) begin
            kind       = 2'($urandom_range(1, 3));
            bus.dREN   = kind[0];
            bus.dWEN   = kind[1];
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
         end else begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
         end
      end else if ($urandom_range(0, 49) == 0) begin
         bus.dREN = 1'b0;
         bus.dWEN = 1'b0;
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      bus.ramload  = $urandom;
      rst = ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.iREN     = 1'b0;
      bus.iaddr    = 32'h0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = 32'h0;
      bus.dstore   = 32'h0;
      bus.ramstate = 2'd0;
      bus.ramload  = 32'h0;
      rec_en       = 1'b0;
      last_idone   = 1'b0;
      last_ddone   = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;

      // Single instruction fetch
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h40;
      cycle();
      cycle();
      bus.ramstate = 2'd2;
      bus.ramload  = 32'h2402000A;
      #1;
      chk("fetch_ramaddr", bus.ramaddr, 32'h40);
      chk("fetch_iwait",   bus.iwait,   1'b0);
      chk("fetch_iload",   bus.iload,   32'h2402000A);
      cycle();
      bus.iREN     = 1'b0;
      bus.ramstate = 2'd0;
      cycle();

      // Contention: data read+write vs instruction, RAM always ready
      bus.iREN     = 1'b1;
      bus.dREN     = 1'b1;
      bus.dWEN     = 1'b1;
      bus.daddr    = 32'h100;
      bus.dstore   = 32'hDEADBEEF;
      bus.ramstate = 2'd2;
      rec_en       = 1'b1;
      repeat (12) cycle();
      rec_en = 1'b0;
      chk("grant_count", trace.size(), 6);
      for (int k = 0; k < 6 && k < trace.size(); k++)
         chk($sformatf("grant_owner%0d", k), trace[k], (k == 4) ? 2 : 1);
      bus.iREN     = 1'b0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.ramstate = 2'd0;
      cycle();

      // RAM error then retry
      bus.dREN  = 1'b1;
      bus.daddr = 32'h200;
      cycle();
      bus.ramstate = 2'd3;
      cycle();
      bus.ramstate = 2'd0;
      cycle();
      bus.ramstate = 2'd2;
      bus.ramload  = 32'hCAFEF00D;
      cycle();
      bus.dREN     = 1'b0;
      bus.ramstate = 2'd0;
      cycle();

      // Long BUSY stall on a write
      bus.dWEN   = 1'b1;
      bus.daddr  = 32'h300;
      bus.dstore = 32'h12345678;
      cycle();
      bus.ramstate = 2'd1;
      repeat (10) cycle();
      bus.ramstate = 2'd2;
      cycle();
      bus.dWEN     = 1'b0;
      bus.ramstate = 2'd0;
      cycle();

      // Reset in the middle of a data grant
      bus.dREN  = 1'b1;
      bus.daddr = 32'h400;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      bus.ramstate = 2'd2;
      #1;
      chk("regrant_ramREN",  bus.ramREN,  1'b1);
      chk("regrant_ramaddr", bus.ramaddr, 32'h400);
      cycle();
      bus.dREN     = 1'b0;
      bus.ramstate = 2'd0;
      cycle();

      // Randomized traffic
      repeat (3000) begin
         drive_random();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
